lfsr_word_buffer: RTL
=====================

# lfsr_word_buffer

Downstream consumer of the 32-bit LFSR. It drives the LFSR's `enable`, decimates the one-bit-per-clock shift stream so every delivered word contains WIDTH fresh shifts, and buffers words in a small FIFO behind a valid/ready output port. It also detects the XNOR lock-up state (all ones) and halts generation until software clears it.

## Interface
- WIDTH, 32: word width. Must equal the LFSR width.
- DEPTH, 8: FIFO depth in words. Power of 2, ≥2.
- DECIM, 32: LFSR shifts per captured word. Range 1..WIDTH.
- clock  in  1  rising-edge clock shared with the LFSR.
- reset_n  in  1  asynchronous, active-low reset. All state clears immediately on assertion.
- lfsr_seq  in  WIDTH  LFSR parallel state, sampled as-is.
- lfsr_en  out  1  drives the LFSR `enable` input.
- run  in  1  level; generation is requested while high.
- m_valid  out  1  head word available.
- m_ready  in  1  consumer accepts the head word.
- m_data  out  WIDTH  head word; 0 when m_valid=0.
- count  out  $clog2(DEPTH)+1  words currently stored.
- lockup  out  1  sticky; an all-ones word was captured.
- clear_lockup  in  1  single-cycle pulse; clears lockup and the decimation counter.

## Operation
- State:
  - shift counter sc, 0..DECIM-1.
  - capture flag pend.
  - FIFO with rd/wr pointers, DEPTH entries, and count.
  - lockup flag.
- lfsr_en (combinational) = run && !lockup && (count + pend) < DEPTH.
- On each edge with lfsr_en=1:
  - If sc == DECIM-1: sc←0, pend←1.
  - Otherwise: sc←sc+1.
- On each edge with pend=1:
  - pend←0 (unless re-set by the rule above in the same cycle, possible only when DECIM=1).
  - If lfsr_seq == all ones: do not write the word; set lockup←1.
  - Otherwise: write lfsr_seq to FIFO[wr], wr←wr+1.
  - The sampled value is the pre-edge lfsr_seq, i.e. the state after exactly DECIM shifts since the previous capture.
- Pop: on an edge with m_valid && m_ready, rd←rd+1.
- count update:
  - Push and pop in the same cycle: count unchanged.
  - Otherwise: count +1 on push, −1 on pop.
- A push can never find the FIFO full; lfsr_en gating guarantees space. Verification asserts this.
- Pointers wrap modulo DEPTH.
- run=0 mid-decimation: sc and pend hold. A pending capture still completes. Shifting resumes from the same sc when run returns high.
- lockup=1:
  - lfsr_en=0.
  - FIFO contents remain readable.
  - A pend already set completes its capture.
- clear_lockup:
  - lockup←0, sc←0.
  - Takes priority over a same-cycle capture's lockup set.
  - A same-cycle all-ones capture is discarded and does not re-set lockup.
- m_valid = (count != 0). m_data = FIFO[rd] when valid, else 0.

## Timing
- Reset values: lfsr_en=0, m_valid=0, m_data=0, count=0, lockup=0, sc=0, pend=0, pointers 0.
- Start latency: run rises with the FIFO empty and sc=0.
  - lfsr_en goes high in the same cycle.
  - pend sets on edge DECIM.
  - The word is written on edge DECIM+1.
  - m_valid is high after edge DECIM+1.
- Sustained throughput with m_ready=1: one word per DECIM cycles for DECIM≥2, and one word per cycle for DECIM=1.
- Backpressure:
  - lfsr_en falls combinationally in the cycle where count+pend reaches DEPTH.
  - The LFSR never shifts while the buffer has no room.
- A pop raises lfsr_en in the cycle after the pop edge.
- Reset is asynchronous mid-operation: all state clears, and stored words are lost.

## Test plan
- Reset/idle: reset_n low, then high with run=0 → all outputs 0 and lfsr_en=0 for 100 cycles.
- Latency and capture (DECIM=32): bench drives lfsr_seq=0xA5A5_0001 from cycle 30, run=1 from cycle 0 → lfsr_en high for 32 cycles, m_valid rises after edge 33, m_data=0xA5A5_0001, count=1.
- Fill and backpressure (DEPTH=8, m_ready=0): run=1 → count saturates at 8, lfsr_en=0 for exactly 8×32 enabled edges total. One pop → lfsr_en high for 32 more cycles, count returns to 8.
- Simultaneous push/pop (DECIM=1, m_ready=1, lfsr_seq incrementing): count stays at 1, m_data sequence strictly increasing, no word lost or duplicated.
- Lock-up: lfsr_seq=0xFFFF_FFFF at capture → lockup=1, count unchanged, lfsr_en=0 despite run=1. clear_lockup pulse → lockup=0, sc=0, generation resumes.
- Async reset mid-fill: count=5, assert reset_n between edges → count, m_valid and lfsr_en drop to 0 without a clock edge.

Source files
------------

// File: rtl/lfsr_word_buffer_if.sv
// Valid/ready word stream carrying captured LFSR words to the consumer.
interface lfsr_word_buffer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/lfsr_word_buffer.sv
// Decimates a free-running LFSR into WIDTH-bit words, buffers them in a small FIFO
// behind a valid/ready port, and halts generation on the XNOR lock-up (all ones) state.
module lfsr_word_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DECIM = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         lfsr_seq,
    output logic                     lfsr_en,
    input  logic                     run,
    lfsr_word_buffer_if.master       m,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     lockup,
    input  logic                     clear_lockup
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [SW-1:0]    sc_q;
    logic             pend_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CW-1:0]    count_q;
    logic             lockup_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wrap_c;
    logic             all_ones_c;
    logic             push_c;
    logic             pop_c;
    logic [CW:0]      fill_c;

    // Words stored plus the one in flight must leave room, so a push never meets a full FIFO.
    always_comb begin
        fill_c     = {1'b0, count_q} + (CW+1)'(pend_q);
        wrap_c     = (sc_q == SW'(DECIM - 1));
        all_ones_c = &lfsr_seq;
        lfsr_en    = reset_n && run && !lockup_q && (fill_c < (CW+1)'(DEPTH));
        push_c     = pend_q && !all_ones_c;
        pop_c      = (count_q != '0) && m.m_ready;
    end

    assign m.m_valid = (count_q != '0);
    assign m.m_data  = (count_q != '0) ? mem[rd_q] : '0;
    assign count     = count_q;
    assign lockup    = lockup_q;

    // Decimation counter, capture flag, lock-up flag and FIFO bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sc_q     <= '0;
            pend_q   <= 1'b0;
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            lockup_q <= 1'b0;
        end else begin
            if (clear_lockup) begin
                sc_q <= '0;
            end else if (lfsr_en) begin
                sc_q <= wrap_c ? '0 : sc_q + SW'(1);
            end
            pend_q <= lfsr_en && wrap_c;

            // Clearing wins over a same-cycle all-ones capture, which is simply dropped.
            if (clear_lockup) begin
                lockup_q <= 1'b0;
            end else if (pend_q && all_ones_c) begin
                lockup_q <= 1'b1;
            end

            if (push_c) wr_q <= wr_q + AW'(1);
            if (pop_c)  rd_q <= rd_q + AW'(1);

            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; m_data is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push_c) mem[wr_q] <= lfsr_seq;
    end
endmodule
